// File: rtl/slave_mem_responder.sv
// ---------------------------------------------------------------------------
// slave_mem_responder
//   Memory-backed slave endpoint for the crossbar master/slave request
//   protocol. This is the target behind one crossbar slave-side port; the
//   m_s_ifc slave_port modport signals appear here as flat ports.
//   It accepts one transaction at a time. The accept latency and the read
//   latency are programmable. Writes are stored in a DEPTH x 32 memory, and
//   read data comes back RD_LATENCY cycles after the ack.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   ACK_LATENCY  cycles from the first sampled req to the ack cycle (>= 1)
//   RD_LATENCY   cycles from a read's ack cycle to its resp cycle (>= 1)
//
// Ports
//   clk                 clock, rising edge
//   rst_n               synchronous active-low reset
//   master_slave_req    request valid, held with addr/cmd/wdata until ack
//   master_slave_addr   byte address, word aligned
//   master_slave_cmd    0 = read, 1 = write
//   master_slave_wdata  write data
//   slave_master_ack    one-cycle acceptance pulse
//   slave_master_rdata  read data, non-zero only while resp is high
//   slave_master_resp   one-cycle read-data-valid pulse
//
// Optional feature (macro SLV_ADDR_CHECK_EN)
//   Defined:   addresses with addr[31:2] >= DEPTH are out of range. An
//              out-of-range write is acked and dropped. An out-of-range read
//              is acked and returns 32'hDEAD_BEEF.
//   Undefined: no range check. Addresses alias modulo DEPTH*4.
// ---------------------------------------------------------------------------
module slave_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ACK_LATENCY = 1,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        master_slave_req,
  input  logic [31:0] master_slave_addr,
  input  logic        master_slave_cmd,
  input  logic [31:0] master_slave_wdata,
  output logic        slave_master_ack,
  output logic [31:0] slave_master_rdata,
  output logic        slave_master_resp
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned MAX_LAT  = (ACK_LATENCY > RD_LATENCY) ? ACK_LATENCY : RD_LATENCY;
  localparam int unsigned CNT_W    = $clog2(MAX_LAT + 1);
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ACK     = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               resp_q, resp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        cap_q, cap_d;
  logic               mem_we_c;
  logic [IDX_W-1:0]   idx_c;
  logic               in_range_c;
  logic [31:0]        rd_word_c;
  logic               unused_addr_c;

  logic [31:0]        mem_q [DEPTH];

  // Word index: the byte-offset bits and the bits above the index are dropped.
  assign idx_c = master_slave_addr[2 +: IDX_W];

  // Parity of the whole address keeps the bits that feed no logic visible to lint.
  assign unused_addr_c = ^master_slave_addr;

`ifdef SLV_ADDR_CHECK_EN
  // Any word address at or beyond DEPTH is out of range.
  assign in_range_c = (master_slave_addr[31:2] < 30'(DEPTH));
`else
  assign in_range_c = 1'b1;
`endif

  // Word returned by a read committed this cycle.
  assign rd_word_c = in_range_c ? mem_q[idx_c] : OOR_DATA;

  // Next-state, counter, commit and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    mem_we_c = 1'b0;
    ack_d    = 1'b0;
    resp_d   = 1'b0;
    rdata_d  = '0;

    case (state_q)
      IDLE: begin
        if (master_slave_req) begin
          if (ACK_LATENCY == 1) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(ACK_LATENCY - 1);
          end
        end
      end

      // req is not re-checked here; the commit uses the values held at the ACK edge.
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
        end
      end

      // The closing edge of the ack cycle commits the transaction.
      ACK: begin
        if (master_slave_cmd) begin
          mem_we_c = in_range_c;
          state_d  = IDLE;
        end else begin
          cap_d = rd_word_c;
          if (RD_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end
        end
      end

      RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of the decode of the next state.
    ack_d   = (state_d == ACK);
    resp_d  = (state_d == RESP);
    rdata_d = resp_d ? cap_d : '0;
  end

  // State, counter, capture and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset. A write whose commit edge sees reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      mem_q[idx_c] <= master_slave_wdata;
    end
  end

  assign slave_master_ack   = ack_q;
  assign slave_master_resp  = resp_q;
  assign slave_master_rdata = rdata_q;

endmodule
